// File: rtl/hdr_rd_pkg.sv
// Shared definitions for the header RAM read sequencer: FSM encoding and
// output buffer depth.
package hdr_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/hdr_ram_reader_if.sv
// Word stream from the header RAM reader to the readout formatter.
// A word transfers on every cycle where out_valid & out_ready; once raised, out_valid holds with stable data/last until that handshake.
interface hdr_ram_reader_if #(
    parameter int RAM_WIDTH = 9
);
    logic [RAM_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (output out_data, out_valid, out_last, input out_ready);
    modport slave  (input out_data, out_valid, out_last, output out_ready);
endinterface

// File: rtl/hdr_skid_fifo.sv
// Two-entry FIFO holding {data, last} words returned by the RAM until the
// downstream stream accepts them.
module hdr_skid_fifo
    import hdr_rd_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/hdr_ram_reader.sv
// Walks a block of header RAM addresses over read port B and streams the
// returned words out, absorbing the one-cycle RAM latency and backpressure.
module hdr_ram_reader
    import hdr_rd_pkg::*;
#(
    parameter int RAM_WIDTH = 9,
    parameter int RAM_ADRB  = 11
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [RAM_ADRB-1:0] start_adr,
    input  logic [RAM_ADRB:0]   word_count,
    output logic                busy,
    output logic                done,
    output logic                rd_enb,
    output logic [RAM_ADRB-1:0] rd_adrb,
    input  logic [RAM_WIDTH-1:0] rd_datab,
    hdr_ram_reader_if.master    strm,
    output state_t              fsm_state
);

    state_t               state;
    logic [RAM_ADRB-1:0]  adr;
    logic [RAM_ADRB-1:0]  last_adr;
    logic [RAM_ADRB:0]    remaining;
    logic                 inflight;
    logic                 inflight_last;
    logic [1:0]           fifo_count;
    logic [RAM_WIDTH:0]   head;
    logic                 valid;
    logic                 pop;
    logic                 credit_ok;
    logic                 issue;
    logic                 is_last;

    assign valid = (fifo_count != 2'd0);
    assign pop   = valid & strm.out_ready;

    // A word popped this cycle frees its slot in time for a read issued now,
    // which is what sustains one word per cycle through a two-entry buffer.
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop}) < 3'(FIFO_DEPTH);
    assign issue     = (state == FETCH) && credit_ok;
    assign is_last   = (remaining == {{RAM_ADRB{1'b0}}, 1'b1});

    assign rd_enb  = issue;
    assign rd_adrb = issue ? adr : last_adr;

    assign strm.out_valid = valid;
    assign strm.out_data  = head[RAM_WIDTH:1];
    assign strm.out_last  = valid & head[0];
    assign fsm_state      = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            adr           <= '0;
            last_adr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue & is_last;
            if (issue) begin
                adr       <= adr + 1'b1;
                last_adr  <= adr;
                remaining <= remaining - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        adr       <= start_adr;
                        remaining <= word_count;
                        busy      <= 1'b1;
                        if (word_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue && is_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && head[0]) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    hdr_skid_fifo #(.WIDTH(RAM_WIDTH + 1)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight),
        .push_data ({rd_datab, inflight_last}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

endmodule
